chunked_alu: RTL and testbench

- Parametrised multi-word successor to the single-cycle 6-bit adder tile.
- Operands of 6*NCHUNK bits are streamed in over the 12-bit io_in harness one 6-bit chunk per cycle, LSB chunk first.
- Add, subtract or accumulate is performed chunk-serially with a registered carry, and the result is streamed back out on io_out.
- Sits directly behind the tapeout harness mux, gated by the harness ready/reset.

---
 rtl/chunked_alu.sv | 198 +++++++++++++++++++
 tb/tb_chunked_alu.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_alu.sv
// chunked_alu: chunk-serial add / subtract / accumulate behind the 12-bit
// tapeout harness. Operands arrive LSB chunk first, six bits per cycle,
// are combined with a registered carry, and stream back out LSB first.
module chunked_alu #(
  parameter int NCHUNK  = 4,
  parameter bit ACC_SAT = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] io_in,
  output logic [11:0] io_out
);

  localparam int         W    = 6 * NCHUNK;
  localparam logic [3:0] LAST = 4'(NCHUNK - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    COMPUTE = 3'd3,
    OUTPUT  = 3'd4
  } state_t;

  logic [5:0] chunk;
  logic       in_valid;
  logic [1:0] op_in;
  logic       abort;
  logic       unused_in;

  assign chunk     = io_in[5:0];
  assign in_valid  = io_in[6];
  assign op_in     = io_in[8:7];
  assign abort     = io_in[9];
  assign unused_in = ^io_in[11:10];

  state_t     state;
  logic [1:0] op;
  logic [W-1:0] a_reg, b_reg, res_reg, acc;
  logic       carry;
  logic       flag_reg;
  logic [3:0] cnt;
  logic [3:0] stat;
  logic [5:0] out_data;
  logic       out_valid;
  logic       out_flag;

  // Operands and result are shift registers: new chunks enter at the top,
  // so after NCHUNK shifts chunk 0 sits in the low six bits.
  logic [W-1:0] a_next, b_next, res_next, res_final;
  logic [5:0]   b_term;
  logic [6:0]   sum;

  assign a_next    = W'({chunk, a_reg} >> 6);
  assign b_next    = W'({chunk, b_reg} >> 6);
  assign b_term    = (op == OP_SUB) ? ~b_reg[5:0] : b_reg[5:0];
  assign sum       = {1'b0, a_reg[5:0]} + {1'b0, b_term} + {6'b0, carry};
  assign res_next  = W'({sum[5:0], res_reg} >> 6);
  assign res_final = (op == OP_ACC && ACC_SAT && sum[6]) ? {W{1'b1}} : res_next;

  assign io_out = {stat, out_flag, out_valid, out_data};

  // Status nibble mirrors the state being entered: {state code, busy}.
  function automatic logic [3:0] status_of(input state_t s);
    return {s, (s != IDLE)};
  endfunction

  // Whole controller: operand loading, serial arithmetic, result streaming.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      op        <= OP_ADD;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      flag_reg  <= 1'b0;
      cnt       <= '0;
      stat      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_flag  <= 1'b0;
    end else begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_flag  <= 1'b0;
      if (state != IDLE && abort) begin
        state <= IDLE;
        stat  <= status_of(IDLE);
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (in_valid) begin
              if (op_in == OP_CLR) begin
                acc <= '0;
              end else begin
                op    <= op_in;
                a_reg <= a_next;
                if (NCHUNK == 1) begin
                  cnt <= '0;
                  if (op_in == OP_ACC) begin
                    b_reg <= acc;
                    carry <= 1'b0;
                    state <= COMPUTE;
                    stat  <= status_of(COMPUTE);
                  end else begin
                    state <= LOAD_B;
                    stat  <= status_of(LOAD_B);
                  end
                end else begin
                  cnt   <= 4'd1;
                  state <= LOAD_A;
                  stat  <= status_of(LOAD_A);
                end
              end
            end
          end
          LOAD_A: begin
            if (in_valid) begin
              a_reg <= a_next;
              if (cnt == LAST) begin
                cnt <= '0;
                if (op == OP_ACC) begin
                  b_reg <= acc;
                  carry <= 1'b0;
                  state <= COMPUTE;
                  stat  <= status_of(COMPUTE);
                end else begin
                  state <= LOAD_B;
                  stat  <= status_of(LOAD_B);
                end
              end else begin
                cnt <= cnt + 4'd1;
              end
            end
          end
          LOAD_B: begin
            if (in_valid) begin
              b_reg <= b_next;
              if (cnt == LAST) begin
                cnt   <= '0;
                carry <= (op == OP_SUB);
                state <= COMPUTE;
                stat  <= status_of(COMPUTE);
              end else begin
                cnt <= cnt + 4'd1;
              end
            end
          end
          COMPUTE: begin
            a_reg <= a_reg >> 6;
            b_reg <= b_reg >> 6;
            carry <= sum[6];
            if (cnt == LAST) begin
              cnt      <= '0;
              res_reg  <= res_final;
              flag_reg <= (op == OP_SUB) ? ~sum[6] : sum[6];
              if (op == OP_ACC) begin
                acc <= res_final;
              end
              state <= OUTPUT;
              stat  <= status_of(OUTPUT);
            end else begin
              res_reg <= res_next;
              cnt     <= cnt + 4'd1;
            end
          end
          OUTPUT: begin
            out_data  <= res_reg[5:0];
            out_valid <= 1'b1;
            res_reg   <= res_reg >> 6;
            if (cnt == LAST) begin
              out_flag <= flag_reg;
              cnt      <= '0;
              state    <= IDLE;
              stat     <= status_of(IDLE);
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          default: begin
            state <= IDLE;
            stat  <= status_of(IDLE);
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chunked_alu.sv
// tb_chunked_alu: randomized checks of chunked_alu against an arithmetic
// reference model, across four instances (4 chunks wrap / 4 chunks
// saturating / 1 chunk / 8 chunks).
module tb_chunked_alu;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] io_in_v  [4];
  logic [11:0] io_out_v [4];

  int checks = 0;
  int errors = 0;
  logic [47:0] acc_m [4];

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  chunked_alu #(.NCHUNK(4), .ACC_SAT(1'b0)) u_n4 (
    .clock(clock), .reset(reset), .io_in(io_in_v[0]), .io_out(io_out_v[0]));
  chunked_alu #(.NCHUNK(4), .ACC_SAT(1'b1)) u_n4_sat (
    .clock(clock), .reset(reset), .io_in(io_in_v[1]), .io_out(io_out_v[1]));
  chunked_alu #(.NCHUNK(1), .ACC_SAT(1'b0)) u_n1 (
    .clock(clock), .reset(reset), .io_in(io_in_v[2]), .io_out(io_out_v[2]));
  chunked_alu #(.NCHUNK(8), .ACC_SAT(1'b0)) u_n8 (
    .clock(clock), .reset(reset), .io_in(io_in_v[3]), .io_out(io_out_v[3]));

  function automatic int nck(input int sel);
    case (sel)
      2:       return 1;
      3:       return 8;
      default: return 4;
    endcase
  endfunction

  function automatic logic [47:0] mask_of(input int sel);
    return (48'h1 << (6 * nck(sel))) - 48'h1;
  endfunction

  function automatic logic [47:0] rand_word(input int sel);
    return {16'($urandom), 32'($urandom)} & mask_of(sel);
  endfunction

  // Reference: plain modular arithmetic on whole operands; returns {flag, result}.
  function automatic logic [48:0] model(input int sel, input logic [1:0] op,
                                        input logic [47:0] a, input logic [47:0] b);
    logic [48:0] full;
    logic [47:0] m;
    logic [47:0] r;
    logic        f;
    int          w;
    m = mask_of(sel);
    w = 6 * nck(sel);
    r = '0;
    f = 1'b0;
    full = '0;
    case (op)
      OP_ADD: begin
        full = {1'b0, a} + {1'b0, b};
        r = full[47:0] & m;
        f = full[w];
      end
      OP_SUB: begin
        r = (a - b) & m;
        f = (a < b);
      end
      OP_ACC: begin
        full = {1'b0, acc_m[sel]} + {1'b0, a};
        r = full[47:0] & m;
        f = full[w];
        if (sel == 1 && f) r = m;
        acc_m[sel] = r;
      end
      default: acc_m[sel] = '0;
    endcase
    return {f, r};
  endfunction

  // Drive one operation and collect the streamed result with a cycle budget.
  task automatic do_op(input int sel, input logic [1:0] op, input logic [47:0] a,
                       input logic [47:0] b, input int gap,
                       output logic [47:0] res, output logic flg, output int lat,
                       output int cnt, output logic stream_bad);
    int n;
    int nops;
    logic [47:0] w;
    n = nck(sel);
    nops = (op == OP_ACC) ? 1 : 2;
    for (int k = 0; k < nops; k++) begin
      w = (k == 0) ? a : b;
      for (int i = 0; i < n; i++) begin
        if (gap > 0 && (k + i) > 0) begin
          repeat (gap) begin
            @(negedge clock);
            io_in_v[sel] = {2'($urandom), 1'b0, op, 1'b0, 6'($urandom)};
          end
        end
        @(negedge clock);
        io_in_v[sel] = {2'($urandom), 1'b0, op, 1'b1, w[i*6 +: 6]};
      end
    end
    res = '0;
    flg = 1'b0;
    lat = -1;
    cnt = 0;
    stream_bad = 1'b0;
    for (int m = 1; m <= 3 * n + 10 && cnt < n; m++) begin
      @(negedge clock);
      if (m == 1) io_in_v[sel] = '0;
      if (io_out_v[sel][6]) begin
        if (lat < 0) lat = m;
        res[cnt*6 +: 6] = io_out_v[sel][5:0];
        if (cnt == n - 1) flg = io_out_v[sel][7];
        else if (io_out_v[sel][7]) stream_bad = 1'b1;
        cnt++;
      end else if (lat >= 0 || io_out_v[sel][7:0] != 8'h0) begin
        stream_bad = 1'b1;
      end
    end
    @(negedge clock);
    if (io_out_v[sel][7:0] != 8'h0) stream_bad = 1'b1;
  endtask

  task automatic do_clr(input int sel);
    @(negedge clock);
    io_in_v[sel] = {2'b00, 1'b0, OP_CLR, 1'b1, 6'($urandom)};
    @(negedge clock);
    io_in_v[sel] = '0;
    acc_m[sel] = '0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (io_out_v[i] !== 12'h000) begin
        errors++;
        $display("[TB] FAIL reset_hold dut=%0d got %h want 000", i, io_out_v[i]);
      end
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (io_out_v[i] !== 12'h000) begin
        errors++;
        $display("[TB] FAIL reset_release dut=%0d got %h want 000", i, io_out_v[i]);
      end
    end
  endtask

  task automatic test_add();
    logic [47:0] a, b, res;
    logic [48:0] exp;
    logic flg, bad;
    int lat, cnt;
    for (int t = 0; t < 5; t++) begin
      if (t == 0) begin a = 48'h000001; b = 48'hFFFFFF; end
      else begin a = rand_word(0); b = rand_word(0); end
      exp = model(0, OP_ADD, a, b);
      do_op(0, OP_ADD, a, b, 0, res, flg, lat, cnt, bad);
      checks++;
      if (res !== exp[47:0] || flg !== exp[48]) begin
        errors++;
        $display("[TB] FAIL add_value got %h/%b want %h/%b", res, flg, exp[47:0], exp[48]);
      end
      checks++;
      if (cnt != 4 || lat != 6 || bad) begin
        errors++;
        $display("[TB] FAIL add_timing got len=%0d lat=%0d bad=%b want len=4 lat=6", cnt, lat, bad);
      end
    end
  endtask

  task automatic test_sub();
    logic [47:0] a, b, res;
    logic [48:0] exp;
    logic flg, bad;
    int lat, cnt;
    for (int t = 0; t < 6; t++) begin
      if (t == 0) begin a = 48'd5; b = 48'd7; end
      else if (t == 1) begin a = 48'd7; b = 48'd5; end
      else begin a = rand_word(0); b = rand_word(0); end
      exp = model(0, OP_SUB, a, b);
      do_op(0, OP_SUB, a, b, 0, res, flg, lat, cnt, bad);
      checks++;
      if (res !== exp[47:0] || flg !== exp[48] || cnt != 4 || bad) begin
        errors++;
        $display("[TB] FAIL sub_value got %h/%b len=%0d want %h/%b", res, flg, cnt, exp[47:0], exp[48]);
      end
    end
  endtask

  task automatic test_acc();
    logic [47:0] a, res;
    logic [48:0] exp;
    logic flg, bad;
    int lat, cnt;
    for (int sel = 0; sel < 2; sel++) begin
      do_clr(sel);
      checks++;
      if (io_out_v[sel][8:6] !== 3'b000) begin
        errors++;
        $display("[TB] FAIL clr_idle dut=%0d got %b want 000", sel, io_out_v[sel][8:6]);
      end
      for (int t = 0; t < 5; t++) begin
        if (t < 2) a = 48'h800000;
        else if (t == 2) a = 48'h0;
        else a = rand_word(sel);
        exp = model(sel, OP_ACC, a, 48'h0);
        do_op(sel, OP_ACC, a, 48'h0, 0, res, flg, lat, cnt, bad);
        checks++;
        if (res !== exp[47:0] || flg !== exp[48] || cnt != 4 || lat != 6 || bad) begin
          errors++;
          $display("[TB] FAIL acc_value dut=%0d got %h/%b len=%0d lat=%0d want %h/%b",
                   sel, res, flg, cnt, lat, exp[47:0], exp[48]);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [47:0] a, b, res;
    logic [48:0] exp;
    logic flg, bad;
    int lat, cnt;
    logic [1:0] op;
    for (int t = 0; t < 4; t++) begin
      op = (t % 2 == 0) ? OP_ADD : OP_SUB;
      a = rand_word(0);
      b = rand_word(0);
      exp = model(0, op, a, b);
      do_op(0, op, a, b, 3, res, flg, lat, cnt, bad);
      checks++;
      if (res !== exp[47:0] || flg !== exp[48] || cnt != 4 || lat != 6 || bad) begin
        errors++;
        $display("[TB] FAIL stall_value got %h/%b len=%0d lat=%0d want %h/%b",
                 res, flg, cnt, lat, exp[47:0], exp[48]);
      end
    end
  endtask

  task automatic test_abort();
    logic [47:0] a, b, res;
    logic [48:0] exp;
    logic flg, bad;
    int lat, cnt;
    a = rand_word(0) | 48'h1;
    exp = model(0, OP_ACC, a, 48'h0);
    do_op(0, OP_ACC, a, 48'h0, 0, res, flg, lat, cnt, bad);
    b = rand_word(0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      io_in_v[0] = {2'b00, 1'b0, OP_ADD, 1'b1, a[i*6 +: 6]};
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      io_in_v[0] = {2'b00, 1'b0, OP_ADD, 1'b1, b[i*6 +: 6]};
    end
    @(negedge clock);
    checks++;
    if (io_out_v[0][11:8] !== 4'b0101) begin
      errors++;
      $display("[TB] FAIL abort_in_load_b got %b want 0101", io_out_v[0][11:8]);
    end
    io_in_v[0] = {2'b00, 1'b1, OP_ADD, 1'b1, b[12 +: 6]};
    @(negedge clock);
    io_in_v[0] = '0;
    checks++;
    if (io_out_v[0] !== 12'h000) begin
      errors++;
      $display("[TB] FAIL abort_busy got %h want 000", io_out_v[0]);
    end
    exp = model(0, OP_ACC, 48'h0, 48'h0);
    do_op(0, OP_ACC, 48'h0, 48'h0, 0, res, flg, lat, cnt, bad);
    checks++;
    if (res !== exp[47:0] || flg !== exp[48] || cnt != 4 || bad) begin
      errors++;
      $display("[TB] FAIL abort_acc_kept got %h/%b want %h/%b", res, flg, exp[47:0], exp[48]);
    end
  endtask

  task automatic test_reset_mid();
    logic [47:0] a, res;
    logic [48:0] exp;
    logic flg, bad, seen;
    int lat, cnt;
    a = rand_word(0) | 48'h40;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      io_in_v[0] = {2'b00, 1'b0, OP_ACC, 1'b1, a[i*6 +: 6]};
    end
    seen = 1'b0;
    for (int m = 0; m < 20 && !seen; m++) begin
      @(negedge clock);
      io_in_v[0] = '0;
      seen = io_out_v[0][6];
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL reset_mid_output got out_valid=0 want 1 within 20 cycles");
    end
    #2;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (io_out_v[i] !== 12'h000) begin
        errors++;
        $display("[TB] FAIL reset_async dut=%0d got %h want 000", i, io_out_v[i]);
      end
    end
    for (int i = 0; i < 4; i++) acc_m[i] = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (io_out_v[0] !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_idle got %h want 000", io_out_v[0]);
    end
    for (int sel = 0; sel < 2; sel++) begin
      exp = model(sel, OP_ACC, 48'h0, 48'h0);
      do_op(sel, OP_ACC, 48'h0, 48'h0, 0, res, flg, lat, cnt, bad);
      checks++;
      if (res !== exp[47:0] || flg !== exp[48] || cnt != 4 || bad) begin
        errors++;
        $display("[TB] FAIL reset_acc_cleared dut=%0d got %h/%b want %h/%b",
                 sel, res, flg, exp[47:0], exp[48]);
      end
    end
  endtask

  task automatic test_width();
    logic [47:0] a, b, res;
    logic [48:0] exp;
    logic flg, bad;
    int lat, cnt, n;
    logic [1:0] op;
    for (int sel = 2; sel < 4; sel++) begin
      n = nck(sel);
      for (int t = 0; t < 5; t++) begin
        if (t == 0) begin op = OP_ADD; a = mask_of(sel); b = 48'h1; end
        else begin op = 2'($urandom_range(0, 2)); a = rand_word(sel); b = rand_word(sel); end
        exp = model(sel, op, a, b);
        do_op(sel, op, a, b, 0, res, flg, lat, cnt, bad);
        checks++;
        if (res !== exp[47:0] || flg !== exp[48]) begin
          errors++;
          $display("[TB] FAIL width_value n=%0d op=%0d got %h/%b want %h/%b",
                   n, op, res, flg, exp[47:0], exp[48]);
        end
        checks++;
        if (cnt != n || lat != n + 2 || bad) begin
          errors++;
          $display("[TB] FAIL width_timing n=%0d got len=%0d lat=%0d bad=%b want len=%0d lat=%0d",
                   n, cnt, lat, bad, n, n + 2);
        end
      end
    end
  endtask

  // Sequence every scenario, then report.
  initial begin
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      io_in_v[i] = '0;
      acc_m[i] = '0;
    end
    repeat (3) @(negedge clock);
    $display("[TB] starting chunked_alu checks");
    test_reset();
    test_add();
    test_sub();
    test_acc();
    test_stall();
    test_abort();
    test_reset_mid();
    test_width();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
